// File: rtl/mem_pkg.sv
// mem_pkg: access-size encodings, FSM states and alignment helper for mem_access_unit
package mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  // size 2'b11 behaves as a word access
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    return size[1] ? (a != 2'b00) : (size == SZ_HALF) && a[0];
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: selects the load lane from a read word and sign/zero-extends it
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);
  logic [7:0]  w_b;
  logic [15:0] w_h;
  assign w_b  = rdata[{addr, 3'b000} +: 8];
  assign w_h  = addr[1] ? rdata[31:16] : rdata[15:0];
  assign data = size[1] ? rdata
              : (size == SZ_HALF) ? {{16{w_h[15] & ~uns}}, w_h}
              : {{24{w_b[7] & ~uns}}, w_b};
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data memory interface with stall, alignment check and bus timeout
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [1:0]  mem_size_in,
  input  logic        mem_unsigned_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_data_out,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_error
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr, r_wdata, r_data;
  logic [3:0]    r_be;
  logic [1:0]    r_lane, r_size;
  logic          r_we, r_uns, r_berr;
  logic          w_acc, w_mis, w_go, w_tmo;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_ld;
  assign w_acc   = mem_read_in | mem_write_in;
  assign w_mis   = is_misaligned(mem_size_in, addr_in[1:0]);
  assign w_go    = (r_state == IDLE) && w_acc && !w_mis;
  assign w_tmo   = r_cnt == CW'(TIMEOUT - 1);
  assign w_be    = mem_size_in[1] ? 4'hF : (mem_size_in[0] ? 4'h3 : 4'h1) << addr_in[1:0];
  assign w_wdata = mem_size_in[1] ? store_data_in
                 : mem_size_in[0] ? {2{store_data_in[15:0]}} : {4{store_data_in[7:0]}};
  assign dmem_req     = r_state == BUSY;
  assign stall        = !reset && (w_go || r_state == BUSY);
  assign misaligned   = (r_state == IDLE) && w_acc && w_mis;
  assign dmem_we      = r_we;
  assign dmem_addr    = r_addr;
  assign dmem_be      = r_be;
  assign dmem_wdata   = r_wdata;
  assign mem_data_out = r_data;
  assign bus_error    = r_berr;
  load_align u_align (
    .rdata (dmem_rdata),
    .addr  (r_lane),
    .size  (r_size),
    .uns   (r_uns),
    .data  (w_ld)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (w_go) w_next = BUSY;
    if (r_state == BUSY && (dmem_ack || w_tmo)) w_next = DONE;
    if (r_state == DONE) w_next = IDLE;
  end
  // ack wins over a timeout landing in the same cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_data  <= '0;
      r_be    <= '0;
      r_lane  <= '0;
      r_size  <= '0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_berr  <= 1'b0;
    end else begin
      r_berr <= 1'b0;
      if (w_go) begin
        r_cnt   <= '0;
        r_addr  <= {addr_in[31:2], 2'b00};
        r_lane  <= addr_in[1:0];
        r_size  <= mem_size_in;
        r_uns   <= mem_unsigned_in;
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_we    <= mem_write_in;
      end
      if (r_state == BUSY) begin
        if (dmem_ack) begin
          if (!r_we) r_data <= w_ld;
        end else if (w_tmo) begin
          r_data <= '0;
          r_berr <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized scoreboard bench for mem_access_unit against a behavioural model
module tb_mem_access_unit;
  localparam int TMO = 4;
  logic        clock = 1'b0, reset = 1'b1;
  logic        mem_read_in = 1'b0, mem_write_in = 1'b0, mem_unsigned_in = 1'b0;
  logic [1:0]  mem_size_in = 2'b00;
  logic [31:0] addr_in = '0, store_data_in = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0, mem_data_out;
  logic [3:0]  dmem_be;
  logic        stall, misaligned, bus_error;

  always #5 clock = ~clock;

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_size_in(mem_size_in), .mem_unsigned_in(mem_unsigned_in),
    .addr_in(addr_in), .store_data_in(store_data_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_data_out(mem_data_out), .stall(stall),
    .misaligned(misaligned), .bus_error(bus_error)
  );

  typedef struct {logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we;} req_t;
  typedef struct {logic [31:0] data; logic berr;} rsp_t;
  req_t req_q[$];
  rsp_t rsp_q[$];
  req_t cur;
  rsp_t got;
  logic have_cur = 1'b0, prev_req = 1'b0;
  int n_chk = 0, n_fail = 0;
  logic [31:0] last_data = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name, input logic [31:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %h with nothing expected", name, act);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] a,
                                           input logic [1:0] sz, input logic u);
    int unsigned v;
    if (sz >= 2) return rd;
    if (sz == 0) begin
      v = (rd >> (8 * a)) % 256;
      if (!u && v >= 128) v += 32'hFFFF_FF00;
    end else begin
      v = (rd >> (16 * (a / 2))) % 65536;
      if (!u && v >= 32768) v += 32'hFFFF_0000;
    end
    return v;
  endfunction

  // monitor: checks request fields every BUSY cycle and the response on leaving BUSY
  always @(posedge clock) begin
    #1;
    if (reset) begin
      prev_req = 1'b0;
      have_cur = 1'b0;
    end else begin
      if (dmem_req && !prev_req) begin
        if (req_q.size() == 0) fail_now("req_unexpected", dmem_addr);
        else begin
          cur = req_q.pop_front();
          have_cur = 1'b1;
        end
      end
      if (dmem_req && have_cur) begin
        chk("dmem_addr", dmem_addr, cur.addr);
        chk("dmem_be", {28'b0, dmem_be}, {28'b0, cur.be});
        chk("dmem_wdata", dmem_wdata, cur.wdata);
        chk("dmem_we", {31'b0, dmem_we}, {31'b0, cur.we});
      end
      if (!dmem_req && prev_req) begin
        have_cur = 1'b0;
        if (rsp_q.size() == 0) fail_now("rsp_unexpected", mem_data_out);
        else begin
          got = rsp_q.pop_front();
          chk("mem_data_out", mem_data_out, got.data);
          chk("bus_error", {31'b0, bus_error}, {31'b0, got.berr});
        end
      end else if (bus_error) fail_now("bus_error_stray", {31'b0, bus_error});
      prev_req = dmem_req;
    end
  end

  task automatic clear_inputs();
    mem_read_in = 1'b0; mem_write_in = 1'b0; mem_size_in = 2'b00;
    mem_unsigned_in = 1'b0; addr_in = '0; store_data_in = '0;
  endtask

  // lat = BUSY cycle carrying the ack (1..TMO-1), 0 = never ack
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                           input int lat, input string tag);
    logic mis;
    int n;
    req_t rq;
    rsp_t rs;
    @(negedge clock);
    mem_read_in = rd; mem_write_in = wr; mem_size_in = sz; mem_unsigned_in = u;
    addr_in = a; store_data_in = sd; dmem_ack = 1'b0;
    #1;
    mis = (sz == 1 && a % 2 != 0) || (sz >= 2 && a % 4 != 0);
    chk({tag, "_misaligned"}, {31'b0, misaligned}, {31'b0, mis});
    chk({tag, "_stall_idle"}, {31'b0, stall}, {31'b0, !mis});
    if (mis) begin
      @(negedge clock);
      #1 chk({tag, "_noreq"}, {31'b0, dmem_req}, 32'd0);
      clear_inputs();
      return;
    end
    rq.addr  = a - a % 4;
    rq.be    = sz >= 2 ? 4'd15 : (sz == 1 ? 4'd3 : 4'd1) << (a % 4);
    rq.wdata = sz >= 2 ? sd : sz == 1 ? (sd % 65536) * 32'h0001_0001 : (sd % 256) * 32'h0101_0101;
    rq.we    = wr;
    rs.berr  = lat == 0;
    rs.data  = lat == 0 ? 32'd0 : wr ? last_data : ref_load(rdat, a[1:0], sz, u);
    req_q.push_back(rq);
    rsp_q.push_back(rs);
    last_data = rs.data;
    n = lat == 0 ? TMO : lat;
    for (int i = 1; i <= n; i++) begin
      @(negedge clock);
      mem_read_in = 1'($urandom); mem_write_in = 1'($urandom); mem_size_in = 2'($urandom);
      mem_unsigned_in = 1'($urandom); addr_in = $urandom; store_data_in = $urandom;
      dmem_ack = i == lat;
      dmem_rdata = i == lat ? rdat : $urandom;
      #1 chk({tag, "_stall_busy"}, {31'b0, stall}, 32'd1);
    end
    @(negedge clock);
    clear_inputs();
    dmem_ack = 1'($urandom);
    dmem_rdata = $urandom;
    #1;
    chk({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
    chk({tag, "_req_done"}, {31'b0, dmem_req}, 32'd0);
  endtask

  task automatic reset_mid_busy();
    req_t rq;
    @(negedge clock);
    dmem_ack = 1'b0; mem_read_in = 1'b1; mem_size_in = 2'b10; addr_in = 32'h104;
    rq.addr = 32'h104; rq.be = 4'hF; rq.wdata = 32'd0; rq.we = 1'b0;
    req_q.push_back(rq);
    @(negedge clock);
    #1 chk("rst_busy_req", {31'b0, dmem_req}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_req_drop", {31'b0, dmem_req}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    @(negedge clock);
    reset = 1'b0; clear_inputs(); dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    dmem_ack = 1'b0;
    #1;
    chk("rst_late_ack_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_late_ack_stall", {31'b0, stall}, 32'd0);
    chk("rst_late_ack_data", mem_data_out, 32'd0);
    last_data = '0;
  endtask

  initial begin
    logic [1:0] sz;
    logic [31:0] a;
    logic rd, wr;
    mem_read_in = 1'b1; mem_size_in = 2'b10; addr_in = 32'h10;
    repeat (2) @(negedge clock);
    #1;
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_req", {31'b0, dmem_req}, 32'd0);
    chk("reset_we", {31'b0, dmem_we}, 32'd0);
    chk("reset_addr", dmem_addr, 32'd0);
    chk("reset_be", {28'b0, dmem_be}, 32'd0);
    chk("reset_wdata", dmem_wdata, 32'd0);
    chk("reset_data", mem_data_out, 32'd0);
    chk("reset_berr", {31'b0, bus_error}, 32'd0);
    clear_inputs();
    reset = 1'b0;
    do_access(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80AA_BBCC, 2, "lb_103");
    do_access(1, 0, 2'b01, 1, 32'h202, 32'h0, 32'h8001_1234, 1, "lhu_202");
    do_access(0, 1, 2'b00, 0, 32'h301, 32'h5A, 32'h0, 3, "sb_301");
    do_access(1, 0, 2'b10, 0, 32'h102, 32'h0, 32'h0, 1, "lw_misaligned");
    do_access(1, 0, 2'b10, 0, 32'h400, 32'h0, 32'h0, 0, "lw_timeout");
    do_access(1, 1, 2'b11, 0, 32'h504, 32'h1234_5678, 32'h0, 1, "rw_store");
    reset_mid_busy();
    for (int t = 0; t < 150; t++) begin
      sz = 2'($urandom);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & (sz >= 2 ? ~32'h3 : sz == 1 ? ~32'h1 : ~32'h0);
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      do_access(rd, wr, sz, 1'($urandom), a, $urandom, $urandom,
                $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, TMO - 1), "rand");
    end
    repeat (3) @(negedge clock);
    chk("req_q_drained", req_q.size(), 32'd0);
    chk("rsp_q_drained", rsp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
